// File: rtl/memory_multiport_pkg.sv
// Shared types and helpers for the multi-port word memory and its per-channel handshake timers.
package memory_multiport_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_WAIT = 2'd1,
        T_DONE = 2'd2
    } timer_state_t;

    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/memory_multiport_timer.sv
// Handshake timer for one channel: counts stable-request edges up to LATENCY, flags the
// completing edge (fire) and exposes ready only while the latched request is still presented.
module memory_multiport_timer
    import memory_multiport_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic req_changed,
    output logic ready,
    output logic fire
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

    timer_state_t     state_r;
    timer_state_t     state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             fire_s;

    // State and counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= T_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state: a fresh or altered request always restarts the count at one
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        fire_s  = 1'b0;
        if (!valid) begin
            state_s = T_IDLE;
            cnt_s   = {CNT_W{1'b0}};
        end else if ((state_r == T_IDLE) || req_changed) begin
            cnt_s = CNT_ONE;
            if (LATENCY == 1) begin
                state_s = T_DONE;
                fire_s  = 1'b1;
            end else begin
                state_s = T_WAIT;
            end
        end else begin
            case (state_r)
                T_WAIT: begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_PRE) begin
                        state_s = T_DONE;
                        fire_s  = 1'b1;
                    end else begin
                        state_s = T_WAIT;
                    end
                end
                T_DONE: begin
                    state_s = T_DONE;
                    cnt_s   = CNT_LAST;
                end
                default: begin
                    state_s = T_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // A request edited while DONE must not see the old completion
    assign ready = (state_r == T_DONE) & valid & ~req_changed;
    assign fire  = fire_s & ~reset;

endmodule

// File: rtl/memory_multiport.sv
// Word-addressed memory with one byte-strobed write channel and NUM_RD independent read
// channels, each behind a LATENCY-cycle level handshake; reads see same-edge writes.
module memory_multiport
    import memory_multiport_pkg::*;
#(
    parameter int ADDR_BITS = 5,
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 2,
    parameter int LATENCY   = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_W-1:0]                 in_addr,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic [DATA_W/8-1:0]               in_strb,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]     out_addr,
    input  logic [NUM_RD-1:0]                 out_valid,
    output logic [NUM_RD-1:0]                 out_ready,
    output logic [NUM_RD-1:0][DATA_W-1:0]     out_data
);

    localparam int WORD_BYTES = DATA_W / 8;
    localparam int OFF_BITS   = $clog2(WORD_BYTES);
    localparam int DEPTH      = 2 ** ADDR_BITS;

    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic [ADDR_W-1:0]     wr_addr_r;
    logic [DATA_W-1:0]     wr_data_r;
    logic [WORD_BYTES-1:0] wr_strb_r;
    logic                  wr_changed_s;
    logic                  wr_fire_s;
    logic [ADDR_BITS-1:0]  wr_idx_s;
    logic [DATA_W-1:0]     wr_merge_s;

    assign wr_idx_s     = in_addr[OFF_BITS +: ADDR_BITS];
    assign wr_changed_s = (in_addr != wr_addr_r) | (in_data != wr_data_r) | (in_strb != wr_strb_r);

    // Write request latch used to detect a changed request
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
            wr_strb_r <= {WORD_BYTES{1'b0}};
        end else begin
            wr_addr_r <= in_addr;
            wr_data_r <= in_data;
            wr_strb_r <= in_strb;
        end
    end

    memory_multiport_timer #(.LATENCY(LATENCY)) u_wr_timer (
        .clk         (clk),
        .reset       (reset),
        .valid       (in_valid),
        .req_changed (wr_changed_s),
        .ready       (in_ready),
        .fire        (wr_fire_s)
    );

    // Post-write word: strobed bytes from the request, the rest from the array
    always_comb begin
        wr_merge_s = mem_r[wr_idx_s];
        for (int b = 0; b < WORD_BYTES; b++) begin
            wr_merge_s[8*b +: 8] = merge_byte(mem_r[wr_idx_s][8*b +: 8], in_data[8*b +: 8], in_strb[b]);
        end
    end

    // Array update, once per completed write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_idx_s] <= wr_merge_s;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0]    rd_addr_r;
        logic [DATA_W-1:0]    rd_data_r;
        logic [ADDR_BITS-1:0] rd_idx_s;
        logic [DATA_W-1:0]    rd_word_s;
        logic                 rd_changed_s;
        logic                 rd_fire_s;

        assign rd_idx_s     = out_addr[i][OFF_BITS +: ADDR_BITS];
        assign rd_changed_s = (out_addr[i] != rd_addr_r);
        assign rd_word_s    = (wr_fire_s && (rd_idx_s == wr_idx_s)) ? wr_merge_s : mem_r[rd_idx_s];

        memory_multiport_timer #(.LATENCY(LATENCY)) u_rd_timer (
            .clk         (clk),
            .reset       (reset),
            .valid       (out_valid[i]),
            .req_changed (rd_changed_s),
            .ready       (out_ready[i]),
            .fire        (rd_fire_s)
        );

        // Read latch and data; ready high here means the channel stays DONE this edge
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_addr_r <= {ADDR_W{1'b0}};
                rd_data_r <= {DATA_W{1'b0}};
            end else begin
                rd_addr_r <= out_addr[i];
                if (rd_fire_s || out_ready[i]) begin
                    rd_data_r <= rd_word_s;
                end else begin
                    rd_data_r <= rd_data_r;
                end
            end
        end

        assign out_data[i] = rd_data_r;
    end

endmodule

// File: tb/tb_memory_multiport.sv
// Directed bench for memory_multiport: a default instance and a LATENCY=3 / NUM_RD=4 instance,
// both checked every cycle against a request-age model plus hand-computed literals.
module tb_memory_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic [31:0] wa [2];
    logic [31:0] wd [2];
    logic [3:0]  ws [2];
    logic        wv [2];
    logic [31:0] ra [2][4];
    logic        rv [2][4];
    logic        ir [2];
    logic        ordy [2][4];
    logic [31:0] od [2][4];

    logic [1:0][31:0] ra0, od0;
    logic [1:0]       rv0, ordy0;
    logic [3:0][31:0] ra1, od1;
    logic [3:0]       rv1, ordy1;
    logic             ir0, ir1;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ra0[i] = ra[0][i];
            rv0[i] = rv[0][i];
        end
        for (int i = 0; i < 4; i++) begin
            ra1[i] = ra[1][i];
            rv1[i] = rv[1][i];
        end
    end

    always_comb begin
        ir[0] = ir0;
        ir[1] = ir1;
        for (int i = 0; i < 4; i++) begin
            ordy[0][i] = 1'b0;
            od[0][i]   = 32'd0;
            ordy[1][i] = ordy1[i];
            od[1][i]   = od1[i];
        end
        for (int i = 0; i < 2; i++) begin
            ordy[0][i] = ordy0[i];
            od[0][i]   = od0[i];
        end
    end

    memory_multiport u_dut0 (
        .clk(clk), .reset(rst[0]),
        .in_addr(wa[0]), .in_data(wd[0]), .in_strb(ws[0]), .in_valid(wv[0]), .in_ready(ir0),
        .out_addr(ra0), .out_valid(rv0), .out_ready(ordy0), .out_data(od0)
    );

    memory_multiport #(.ADDR_BITS(5), .DATA_W(32), .NUM_RD(4), .LATENCY(3)) u_dut1 (
        .clk(clk), .reset(rst[1]),
        .in_addr(wa[1]), .in_data(wd[1]), .in_strb(ws[1]), .in_valid(wv[1]), .in_ready(ir1),
        .out_addr(ra1), .out_valid(rv1), .out_ready(ordy1), .out_data(od1)
    );

    // Model: age = edges the current request has been held unchanged (saturating at latency)
    int          age [2][5];
    logic [31:0] p_addr [2][5];
    logic [31:0] p_data [2];
    logic [3:0]  p_strb [2];
    logic [31:0] refm [2][32];
    bit          known [2][32];
    logic [31:0] exp_od [2][4];
    bit          od_known [2][4];
    int          total = 0;
    int          bad = 0;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int nrd(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic bit cur_valid(input int d, input int c);
        return (c == 0) ? wv[d] : rv[d][c-1];
    endfunction

    function automatic bit same_req(input int d, input int c);
        if (c == 0) return (wa[d] == p_addr[d][0]) && (wd[d] == p_data[d]) && (ws[d] == p_strb[d]);
        return ra[d][c-1] == p_addr[d][c];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, expv);
        end
    endtask

    task automatic compare_all(input string phase);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d in_ready", phase, d), {31'd0, ir[d]},
                {31'd0, cur_valid(d, 0) && (age[d][0] == lat(d)) && same_req(d, 0)});
            for (int c = 1; c <= nrd(d); c++) begin
                chk($sformatf("%s d%0d rd%0d ready", phase, d, c-1), {31'd0, ordy[d][c-1]},
                    {31'd0, cur_valid(d, c) && (age[d][c] == lat(d)) && same_req(d, c)});
                if (od_known[d][c-1])
                    chk($sformatf("%s d%0d rd%0d data", phase, d, c-1), od[d][c-1], exp_od[d][c-1]);
            end
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                for (int c = 0; c < 5; c++) age[d][c] = 0;
                for (int c = 0; c < 4; c++) begin
                    exp_od[d][c]   = 32'd0;
                    od_known[d][c] = 1'b1;
                end
            end else begin
                for (int c = 0; c <= nrd(d); c++) begin
                    bit fresh;
                    int old;
                    old   = age[d][c];
                    fresh = !((old > 0) && same_req(d, c));
                    if (!cur_valid(d, c)) age[d][c] = 0;
                    else if (fresh) age[d][c] = 1;
                    else if (old < lat(d)) age[d][c] = old + 1;
                    if (c == 0 && age[d][0] == lat(d) && (fresh || old < lat(d))) begin
                        for (int b = 0; b < 4; b++)
                            if (ws[d][b]) refm[d][wa[d][6:2]][8*b +: 8] = wd[d][8*b +: 8];
                        if (ws[d] == 4'hf) known[d][wa[d][6:2]] = 1'b1;
                    end
                    if (c > 0 && age[d][c] == lat(d)) begin
                        exp_od[d][c-1]   = refm[d][ra[d][c-1][6:2]];
                        od_known[d][c-1] = known[d][ra[d][c-1][6:2]];
                    end
                end
            end
            p_addr[d][0] = wa[d];
            p_data[d]    = wd[d];
            p_strb[d]    = ws[d];
            for (int c = 1; c <= nrd(d); c++) p_addr[d][c] = ra[d][c-1];
        end
    endtask

    // One cycle: inputs were driven at the preceding negedge
    task automatic step(input bit do_pre = 1'b1);
        if (do_pre) begin
            #1;
            compare_all("pre");
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all("post");
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
        wa[d] = a;
        wd[d] = v;
        ws[d] = s;
        wv[d] = 1'b1;
    endtask

    task automatic rd(input int d, input int c, input logic [31:0] a);
        ra[d][c] = a;
        rv[d][c] = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            wa[d] = 32'd0; wd[d] = 32'd0; ws[d] = 4'd0; wv[d] = 1'b0;
            for (int c = 0; c < 5; c++) begin
                age[d][c] = 0;
                p_addr[d][c] = 32'd0;
            end
            for (int c = 0; c < 4; c++) begin
                ra[d][c] = 32'd0; rv[d][c] = 1'b0;
                exp_od[d][c] = 32'd0; od_known[d][c] = 1'b1;
            end
            for (int w = 0; w < 32; w++) begin
                refm[d][w] = 32'd0;
                known[d][w] = 1'b0;
            end
        end
        @(negedge clk);
        step(1'b0);
        step(1'b0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();

        // 1: single write, drop, then request/change sequences
        wr(0, 32'h24, 32'hefefefef, 4'hf); step();
        chk("t1 ready held", {31'd0, ir[0]}, 32'd1);
        wv[0] = 1'b0; step();
        chk("t1 ready dropped", {31'd0, ir[0]}, 32'd0);
        wr(0, 32'h28, 32'hc3c3c3c3, 4'hf); step();
        wr(0, 32'h20, 32'h00000000, 4'hf); #1;
        chk("t1 ready masked on change", {31'd0, ir[0]}, 32'd0);
        step(1'b0);
        chk("t1 ready second", {31'd0, ir[0]}, 32'd1);
        wv[0] = 1'b0;

        // 2: two reads in one cycle, then retarget ch0
        rd(0, 0, 32'h28); rd(0, 1, 32'h24); step();
        chk("t2 rd0 data", od[0][0], 32'hc3c3c3c3);
        chk("t2 rd1 data", od[0][1], 32'hefefefef);
        rd(0, 0, 32'h20); step();
        chk("t2 rd0 new data", od[0][0], 32'h00000000);

        // 3: address aliasing
        wr(0, 32'h10, 32'h87654321, 4'hf); step();
        wr(0, 32'hf010, 32'h12345678, 4'hf); step();
        wv[0] = 1'b0; rd(0, 1, 32'h10); step();
        chk("t3 alias upper", od[0][1], 32'h12345678);
        wr(0, 32'h11, 32'h87654321, 4'hf); step();
        wv[0] = 1'b0; step();
        chk("t3 alias offset", od[0][1], 32'h87654321);

        // 4: byte strobes
        wr(0, 32'h30, 32'h11223344, 4'hf); step();
        wr(0, 32'h30, 32'haabbccdd, 4'h5); step();
        wv[0] = 1'b0; rd(0, 0, 32'h30); step();
        chk("t4 strobe merge", od[0][0], 32'h11bb33dd);
        wr(0, 32'h30, 32'hffffffff, 4'h0); step();
        chk("t4 zero strobe ready", {31'd0, ir[0]}, 32'd1);
        wv[0] = 1'b0; step();
        chk("t4 zero strobe data", od[0][0], 32'h11bb33dd);

        // 5: collisions with a held read and a fresh read
        wr(0, 32'h30, 32'hdeadbeef, 4'hf); step();
        chk("t5 held read tracks", od[0][0], 32'hdeadbeef);
        wr(0, 32'h34, 32'hcafef00d, 4'hf); rd(0, 1, 32'h34); step();
        chk("t5 fresh read write-first", od[0][1], 32'hcafef00d);
        wv[0] = 1'b0; rv[0][0] = 1'b0; rv[0][1] = 1'b0; step();

        // 6: latency 3, reset mid-write, restart on change
        wr(1, 32'h40, 32'h01020304, 4'hf); step();
        chk("t6 lat c1", {31'd0, ir[1]}, 32'd0);
        step();
        chk("t6 lat c2", {31'd0, ir[1]}, 32'd0);
        step();
        chk("t6 lat c3", {31'd0, ir[1]}, 32'd1);
        wv[1] = 1'b0; step();
        wr(1, 32'h40, 32'h55555555, 4'hf); step();
        rst[1] = 1'b1; step();
        chk("t6 reset ready", {31'd0, ir[1]}, 32'd0);
        rst[1] = 1'b0; wv[1] = 1'b0;
        rd(1, 0, 32'h40); rd(1, 3, 32'h40); step(); step(); step();
        chk("t6 reset no write rd3", od[1][3], 32'h01020304);
        chk("t6 reset no write rd0", od[1][0], 32'h01020304);
        rv[1][0] = 1'b0; rv[1][3] = 1'b0;
        wr(1, 32'h48, 32'h11111111, 4'hf); step(); step(); step();
        wr(1, 32'h48, 32'haaaaaaaa, 4'hf); step(); step();
        wr(1, 32'h48, 32'h000000bb, 4'h1); step(); step(); step();
        wv[1] = 1'b0; rd(1, 1, 32'h48); step(); step(); step();
        chk("t6 abandoned no commit", od[1][1], 32'h111111bb);
        rv[1][1] = 1'b0; step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
